fma_line_packer: RTL and testbench
==================================

Name: fma_line_packer

Overview:
- Parametrised successor to the fixed two-lane FMA write buffer. Collects per-lane FMA results and packs them into full memory lines.
- Buffers completed lines in a small FIFO.
- Hands lines to the memory module over a ready/valid handshake.
- Adds flush of partial lines, per-line word count, backpressure and sticky overflow. Sits between the FMA array and the memory write port in the GPU datapath.

Parameters:
- FMA_COUNT, 2, number of FMA lanes; must be >= 1 and <= WORDS_PER_LINE.
- WORD_WIDTH, 16, width of one FMA result.
- LINE_WIDTH, 96, memory line width; must be a multiple of WORD_WIDTH.
- FIFO_DEPTH, 4, completed-line FIFO depth; must be a power of two and >= 2.
- Derived: WORDS_PER_LINE = LINE_WIDTH/WORD_WIDTH (6 at defaults); CNT_W = $clog2(WORDS_PER_LINE+1).

Ports:
- clk_in  input  1  system clock (clk_100mhz domain).
- rst_in  input  1  synchronous, active-low reset.
- fma_out_in  input  WORD_WIDTH*FMA_COUNT  lane results; lane 0 occupies the MSBs.
- fma_valid_in  input  FMA_COUNT  per-lane valid; bit FMA_COUNT-1 is lane 0.
- flush_in  input  1  request to emit the partial line.
- in_ready_out  output  1  high when the FIFO is not full.
- line_out  output  LINE_WIDTH  head-of-FIFO line; word 0 in the MSBs.
- line_words_out  output  CNT_W  number of valid words in line_out (1..WORDS_PER_LINE).
- line_valid_out  output  1  head entry is valid.
- line_ready_in  input  1  consumer accepts the head entry this cycle.
- overflow_out  output  1  sticky flag: words were dropped.

Behaviour:
- Reset (rst_in low at a clock edge):
  - Accumulator is emptied (fill = 0).
  - FIFO is empty; line_valid_out = 0, line_out = 0, line_words_out = 0.
  - in_ready_out = 1 on the first cycle after reset; overflow_out = 0; pending flush is cleared.
  - Reset mid-operation discards all partial and queued data with no output.
- Word acceptance:
  - Valid lanes are packed in lane order (lane 0 first), skipping invalid lanes.
  - Packing starts at accumulator slot `fill`; slot 0 is the MSB word.
  - Accepted only when in_ready_out = 1.
  - When in_ready_out = 0, all valid lanes that cycle are dropped and overflow_out is set. It stays set until reset.
- Line completion:
  - When fill + k reaches or passes WORDS_PER_LINE (k = popcount of valid lanes), the first WORDS_PER_LINE words are pushed to the FIFO with count WORDS_PER_LINE.
  - Surplus words start the new accumulator at slot 0; fill becomes fill + k - WORDS_PER_LINE.
  - At most one push per cycle, guaranteed by FMA_COUNT <= WORDS_PER_LINE.
- Flush:
  - flush_in sets a pending flag.
  - The flush executes on the first cycle with pending = 1, no lane valid and in_ready_out = 1.
  - If fill > 0, the accumulator is pushed with count = fill and unused low slots zeroed; fill becomes 0.
  - If fill = 0, the flush is a no-op.
  - In both cases pending clears. Additional flush_in pulses while pending are merged into the one pending flush.
- FIFO:
  - Registered, first-word-fall-through.
  - A line pushed in cycle N is visible on line_valid_out/line_out in cycle N+1.
  - Pop occurs when line_valid_out & line_ready_in.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - in_ready_out = (occupancy != FIFO_DEPTH), computed from registered occupancy. A push in the cycle occupancy reaches FIFO_DEPTH-1 is legal.
  - Pointers wrap modulo FIFO_DEPTH.
- Output hold: line_out and line_words_out are stable while line_valid_out = 1 and line_ready_in = 0.

Decomposition:
- Package gpu_pkg holds:
  - WORD_WIDTH, LINE_WIDTH and the WORDS_PER_LINE helper.
  - A typedef for a line-with-count struct: {words[WORDS_PER_LINE], count}.
- One sub-module, line_fifo: a parametrised FWFT FIFO with push/pop/full/empty, reusable by the memory module.
- Lane compaction (prefix-popcount placement) stays inline.

Test Plan:
- Defaults; both lanes valid with values 0x0001/0x0002, 0x0003/0x0004, 0x0005/0x0006 on 3 consecutive cycles -> one cycle after the third, line_valid_out = 1, line_out = 0x000100020003000400050006, line_words_out = 6.
- Lane pattern 10,01,11,11 (lane0 = A, lane1 = B, C/D, E/F) -> line A,B,C,D,E,F; then a single word G with flush_in -> line G followed by five zero words, line_words_out = 1.
- line_ready_in held 0 while 5 full lines are offered -> in_ready_out falls after the 4th line is queued; 5th-line words dropped; overflow_out = 1 and stays 1; raising line_ready_in drains exactly 4 lines in order.
- FIFO holding 3 lines; push and pop on the same cycle -> occupancy remains 3, order preserved, in_ready_out stays 1.
- flush_in asserted on the same cycle as valid lanes -> flush deferred to the next idle cycle; the emitted partial line includes those words; flush with fill = 0 emits nothing.
- rst_in low for one cycle with fill = 4 and 2 queued lines -> next cycle line_valid_out = 0, overflow_out = 0; subsequent 6 words form a clean fresh line.

Source files
------------

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared line-packing constants, word-count helper and the
//                line-with-count record used by the GPU write datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int LINE_WIDTH = 96;

    // Number of whole words that fit in one memory line
    function automatic int words_per_line(input int line_w, input int word_w);
        return line_w / word_w;
    endfunction

    localparam int WORDS_PER_LINE = words_per_line(LINE_WIDTH, WORD_WIDTH);
    localparam int CNT_W          = $clog2(WORDS_PER_LINE + 1);

    // Line record: words[0] is the most significant word of the flat line
    typedef struct packed {
        logic [0:WORDS_PER_LINE-1][WORD_WIDTH-1:0] words;
        logic [CNT_W-1:0]                          count;
    } line_t;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/line_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : line_fifo
//  Description : Registered first-word-fall-through FIFO. The head entry is
//                visible on pop_data the cycle after it is written. Pushes
//                while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occupancy;
    logic              do_push;
    logic              do_pop;

    assign empty    = (occupancy == '0);
    assign full     = (occupancy == FULL_OCC);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    // An empty FIFO presents zero so the port is clean straight out of reset
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : line_fifo
`default_nettype wire

// File: rtl/fma_line_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fma_line_packer
//  Description : Compacts per-lane FMA results into memory lines, queues
//                completed (or flushed partial) lines with a word count in a
//                small FWFT FIFO and hands them out over ready/valid. Words
//                offered while the FIFO is full are dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma_line_packer #(
    parameter  int FMA_COUNT      = 2,
    parameter  int WORD_WIDTH     = gpu_pkg::WORD_WIDTH,
    parameter  int LINE_WIDTH     = gpu_pkg::LINE_WIDTH,
    parameter  int FIFO_DEPTH     = 4,
    localparam int WORDS_PER_LINE = gpu_pkg::words_per_line(LINE_WIDTH, WORD_WIDTH),
    localparam int CNT_W          = $clog2(WORDS_PER_LINE + 1)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [WORD_WIDTH*FMA_COUNT-1:0] fma_out_in,
    input  logic [FMA_COUNT-1:0]            fma_valid_in,
    input  logic                            flush_in,
    output logic                            in_ready_out,
    output logic [LINE_WIDTH-1:0]           line_out,
    output logic [CNT_W-1:0]                line_words_out,
    output logic                            line_valid_out,
    input  logic                            line_ready_in,
    output logic                            overflow_out
);

    import gpu_pkg::*;

    localparam int WPL    = WORDS_PER_LINE;
    // Scratch line is twice a line so any surplus after a completed line
    // always has a slot, whatever FMA_COUNT (<= WPL) is
    localparam int EXT_N  = 2 * WPL;
    localparam int DATA_W = LINE_WIDTH + CNT_W;

    generate
        if (FMA_COUNT < 1 || FMA_COUNT > WPL || (LINE_WIDTH % WORD_WIDTH) != 0 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("fma_line_packer: illegal parameter combination");
        end
    endgenerate

    // Accumulator: slot 0 is the MSB word; slots at or beyond fill stay zero
    logic [WORD_WIDTH-1:0] acc      [WPL];
    logic [WORD_WIDTH-1:0] next_acc [WPL];
    logic [WORD_WIDTH-1:0] ext      [EXT_N];
    logic [CNT_W-1:0]      fill;
    logic [CNT_W-1:0]      next_fill;
    logic                  pending;
    logic                  overflow;
    int                    total;

    logic                  any_valid;
    logic                  accept;
    logic                  line_done;
    logic                  flush_go;
    logic                  push;
    logic [LINE_WIDTH-1:0] push_line;
    logic [CNT_W-1:0]      push_count;
    logic [DATA_W-1:0]     pop_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign any_valid    = |fma_valid_in;
    assign in_ready_out = ~fifo_full;
    assign accept       = any_valid & in_ready_out;
    assign line_done    = accept && (total >= WPL);
    // A pending flush only runs on a cycle free of lane traffic
    assign flush_go     = pending & ~any_valid & in_ready_out;
    assign push         = line_done | (flush_go & (fill != '0));
    assign push_count   = line_done ? CNT_W'(WPL) : fill;
    assign overflow_out = overflow;

    // Lane compaction: append valid lanes, lane 0 first, after the filled slots
    always_comb begin
        int pos;
        for (int i = 0; i < EXT_N; i++) ext[i] = '0;
        for (int i = 0; i < WPL; i++) begin
            if (i < int'(fill)) ext[i] = acc[i];
        end
        pos = int'(fill);
        for (int l = 0; l < FMA_COUNT; l++) begin
            if (fma_valid_in[FMA_COUNT-1-l]) begin
                ext[pos] = fma_out_in[(FMA_COUNT-l)*WORD_WIDTH-1 -: WORD_WIDTH];
                pos      = pos + 1;
            end
        end
        total = pos;
    end

    // Flatten the first line of the scratch buffer, word 0 in the MSBs
    always_comb begin
        push_line = '0;
        for (int i = 0; i < WPL; i++) begin
            push_line[(WPL-i)*WORD_WIDTH-1 -: WORD_WIDTH] = ext[i];
        end
    end

    // Next accumulator: roll surplus to slot 0, keep partial, or clear on flush
    always_comb begin
        next_fill = fill;
        for (int i = 0; i < WPL; i++) next_acc[i] = acc[i];
        if (accept) begin
            if (line_done) begin
                for (int i = 0; i < WPL; i++) next_acc[i] = ext[WPL+i];
                next_fill = CNT_W'(total - WPL);
            end else begin
                for (int i = 0; i < WPL; i++) next_acc[i] = ext[i];
                next_fill = CNT_W'(total);
            end
        end else if (flush_go) begin
            for (int i = 0; i < WPL; i++) next_acc[i] = '0;
            next_fill = '0;
        end
    end

    // Accumulator, pending-flush and sticky overflow state
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < WPL; i++) acc[i] <= '0;
            fill     <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < WPL; i++) acc[i] <= next_acc[i];
            fill     <= next_fill;
            // Pulses arriving while a flush is queued merge into it
            pending  <= flush_go ? 1'b0 : (pending | flush_in);
            overflow <= overflow | (any_valid & ~in_ready_out);
        end
    end

    line_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_line_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data ({push_line, push_count}),
        .pop       (line_ready_in),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign line_valid_out = ~fifo_empty;
    assign line_out       = pop_data[DATA_W-1 -: LINE_WIDTH];
    assign line_words_out = pop_data[CNT_W-1:0];

endmodule : fma_line_packer
`default_nettype wire

// File: tb/tb_fma_line_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_line_packer
//  Description : Directed scoreboard bench for fma_line_packer at default
//                parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_line_packer;

    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] fma_out_in;
    logic [1:0]  fma_valid_in;
    logic        flush_in;
    logic        in_ready_out;
    logic [95:0] line_out;
    logic [2:0]  line_words_out;
    logic        line_valid_out;
    logic        line_ready_in;
    logic        overflow_out;

    int    checks   = 0;
    int    failures = 0;
    line_t exp_q[$];

    always #5 clk = ~clk;

    fma_line_packer dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .fma_out_in     (fma_out_in),
        .fma_valid_in   (fma_valid_in),
        .flush_in       (flush_in),
        .in_ready_out   (in_ready_out),
        .line_out       (line_out),
        .line_words_out (line_words_out),
        .line_valid_out (line_valid_out),
        .line_ready_in  (line_ready_in),
        .overflow_out   (overflow_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and act on the next one
    task automatic drive(input logic [1:0] v, input logic [15:0] a, input logic [15:0] b,
                         input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        fma_valid_in  = v;
        fma_out_in    = {a, b};
        flush_in      = fl;
        line_ready_in = rdy;
    endtask

    task automatic send_line(input logic [15:0] base, input logic rdy);
        for (int c = 0; c < 3; c++)
            drive(2'b11, base + 16'(2*c), base + 16'(2*c+1), 1'b0, rdy);
    endtask

    task automatic expect_line(input logic [95:0] l, input logic [2:0] cnt);
        line_t e;
        e.words = l;
        e.count = cnt;
        exp_q.push_back(e);
    endtask

    function automatic logic [95:0] pack6(input logic [15:0] b);
        logic [95:0] r = '0;
        for (int j = 0; j < 6; j++) r = {r[79:0], b + 16'(j)};
        return r;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_lines_left required=0", exp_q.size());
        end
    endtask

    // Monitor: every handshake on the output must match the oldest expectation
    always @(negedge clk) begin
        if (rst_in === 1'b1 && line_valid_out === 1'b1 && line_ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_line actual=%0h/%0d required=none", line_out, line_words_out);
            end else begin
                line_t e;
                e = exp_q.pop_front();
                check("line_data", 128'(line_out), 128'(e.words));
                check("line_count", 128'(line_words_out), 128'(e.count));
            end
        end
    end

    initial begin
        rst_in        = 1'b0;
        fma_valid_in  = '0;
        fma_out_in    = '0;
        flush_in      = 1'b0;
        line_ready_in = 1'b0;

        // Reset state
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("rst_valid", 128'(line_valid_out), 128'(0));
        check("rst_line", 128'(line_out), 128'(0));
        check("rst_words", 128'(line_words_out), 128'(0));
        check("rst_in_ready", 128'(in_ready_out), 128'(1));
        check("rst_overflow", 128'(overflow_out), 128'(0));
        rst_in = 1'b1;

        // Three full-width beats form one line
        expect_line(96'h0001_0002_0003_0004_0005_0006, 3'd6);
        drive(2'b11, 16'h0001, 16'h0002, 1'b0, 1'b1);
        drive(2'b11, 16'h0003, 16'h0004, 1'b0, 1'b1);
        drive(2'b11, 16'h0005, 16'h0006, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        check("t1_valid", 128'(line_valid_out), 128'(1));
        check("t1_words", 128'(line_words_out), 128'(6));

        // Sparse lane patterns, then single word plus flush
        expect_line(96'hAAAA_BBBB_CCCC_DDDD_EEEE_F0F0, 3'd6);
        drive(2'b10, 16'hAAAA, 16'h9999, 1'b0, 1'b1);
        drive(2'b01, 16'h9999, 16'hBBBB, 1'b0, 1'b1);
        drive(2'b11, 16'hCCCC, 16'hDDDD, 1'b0, 1'b1);
        drive(2'b11, 16'hEEEE, 16'hF0F0, 1'b0, 1'b1);
        expect_line(96'h1234_0000_0000_0000_0000_0000, 3'd1);
        drive(2'b10, 16'h1234, 16'h5555, 1'b1, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drain(20);

        // Flush raised alongside traffic waits for an idle cycle
        expect_line(96'h2001_2002_2003_2004_0000_0000, 3'd4);
        drive(2'b11, 16'h2001, 16'h2002, 1'b1, 1'b1);
        drive(2'b11, 16'h2003, 16'h2004, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drain(20);
        // Flush with an empty accumulator emits nothing
        drive(2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
        check("empty_flush_valid", 128'(line_valid_out), 128'(0));

        // Backpressure: four lines fill the FIFO, the fifth is dropped
        for (int n = 0; n < 4; n++) begin
            expect_line(pack6(16'h5000 + 16'(16*n)), 3'd6);
            send_line(16'h5000 + 16'(16*n), 1'b0);
        end
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("bp_full_ready", 128'(in_ready_out), 128'(0));
        check("bp_no_overflow_yet", 128'(overflow_out), 128'(0));
        send_line(16'h5040, 1'b0);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("bp_overflow", 128'(overflow_out), 128'(1));
        check("bp_hold_line", 128'(line_out), 128'(96'h5000_5001_5002_5003_5004_5005));
        check("bp_hold_words", 128'(line_words_out), 128'(6));
        drain(20);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("bp_overflow_sticky", 128'(overflow_out), 128'(1));
        check("bp_ready_back", 128'(in_ready_out), 128'(1));
        check("bp_drained_empty", 128'(line_valid_out), 128'(0));

        // Simultaneous push and pop with three lines queued
        for (int n = 0; n < 3; n++) begin
            expect_line(pack6(16'h6000 + 16'(16*n)), 3'd6);
            send_line(16'h6000 + 16'(16*n), 1'b0);
        end
        expect_line(pack6(16'h6030), 3'd6);
        drive(2'b11, 16'h6030, 16'h6031, 1'b0, 1'b0);
        drive(2'b11, 16'h6032, 16'h6033, 1'b0, 1'b0);
        drive(2'b11, 16'h6034, 16'h6035, 1'b0, 1'b1);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("pp_ready", 128'(in_ready_out), 128'(1));
        check("pp_head", 128'(line_out), 128'(pack6(16'h6010)));
        expect_line(pack6(16'h6040), 3'd6);
        send_line(16'h6040, 1'b0);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("pp_now_full", 128'(in_ready_out), 128'(0));
        drain(20);

        // Mid-operation reset with two queued lines and four buffered words
        check("pre_rst_overflow", 128'(overflow_out), 128'(1));
        send_line(16'h7000, 1'b0);
        send_line(16'h7010, 1'b0);
        drive(2'b11, 16'h7020, 16'h7021, 1'b0, 1'b0);
        drive(2'b11, 16'h7022, 16'h7023, 1'b0, 1'b0);
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("pre_rst_valid", 128'(line_valid_out), 128'(1));
        rst_in = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        rst_in = 1'b1;
        check("mid_rst_valid", 128'(line_valid_out), 128'(0));
        check("mid_rst_overflow", 128'(overflow_out), 128'(0));
        check("mid_rst_words", 128'(line_words_out), 128'(0));
        check("mid_rst_ready", 128'(in_ready_out), 128'(1));
        expect_line(pack6(16'h7100), 3'd6);
        send_line(16'h7100, 1'b1);
        drain(20);

        // Idle tail so any stray output is caught by the monitor
        for (int i = 0; i < 5; i++) drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fma_line_packer
`default_nettype wire
